// File: rtl/rr_mem_arbiter_pkg.sv
// Shared types for the memory arbiter slice: RV32I word type, FSM state enum
// and the port-index width helper.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

package arbiter_types;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Width of a port index; a single-port build still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_mem_arbiter_picker.sv
// Combinational round-robin picker: first pending port after last_grant,
// wrapping modulo NUM_PORTS.
module rr_priority_picker
  import arbiter_types::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int IDX_W = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_PORTS);
      if (!any && pending[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mem_arbiter.sv
// N-port round-robin cache-line arbiter onto one memory port (IDLE/BUSY/DONE).
// Optional RR_ARBITER_WRITE_FIRST_EN restricts arbitration to writers when any exist.
module rr_mem_arbiter
  import arbiter_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata,
  input  logic                             pmem_resp,
  output arb_state_t                       dbg_state
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  // Handshake: a port holds read/write, address and wdata until req_resp[i]
  // pulses (one cycle, in DONE), then drops the request the following cycle.
  arb_state_t           state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant_q;
  logic [NUM_PORTS-1:0] grant_vec_q;

  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] pick_vec;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 pick_is_write;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [LINE_WIDTH-1:0] wdata_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*LINE_WIDTH +: LINE_WIDTH];
  end

  always_comb begin
    pending = req_read | req_write;
`ifdef RR_ARBITER_WRITE_FIRST_EN
    // Dirty-line write-backs drain ahead of fills.
    cand = (|req_write) ? req_write : pending;
`else
    cand = pending;
`endif
  end

  rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .pending    (cand),
    .last_grant (last_grant),
    .grant      (pick_vec),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  // Read+write on one port resolves as a write.
  assign pick_is_write = |(pick_vec & req_write);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDX_W'(NUM_PORTS - 1);
      grant_q      <= '0;
      grant_vec_q  <= '0;
      req_resp     <= '0;
      req_rdata    <= '0;
      pmem_address <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_q      <= pick_idx;
            grant_vec_q  <= pick_vec;
            pmem_address <= addr_arr[pick_idx];
            pmem_wdata   <= wdata_arr[pick_idx];
            pmem_write   <= pick_is_write;
            pmem_read    <= !pick_is_write;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            req_rdata  <= pmem_rdata;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            req_resp   <= grant_vec_q;
            state      <= DONE;
          end
        end
        DONE: begin
          req_resp   <= '0;
          last_grant <= grant_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A port asserting read and write together is a requester bug.
  a_no_dual_cmd: assert property (@(posedge clk) disable iff (rst)
    !(|(req_read & req_write)));
`endif

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Randomized scoreboard bench for rr_mem_arbiter (4 ports, 64-bit lines).
module tb_rr_mem_arbiter;
  import arbiter_types::*;
  import rv32i_types::*;

  localparam int NP = 4;
  localparam int LW = 64;
  localparam int AW = 32;
  localparam int TW = 2 + 1 + AW + LW;

  logic                clk;
  logic                rst;
  logic [NP*AW-1:0]    req_address;
  logic [NP-1:0]       req_read;
  logic [NP-1:0]       req_write;
  logic [NP*LW-1:0]    req_wdata;
  logic [NP-1:0]       req_resp;
  logic [LW-1:0]       req_rdata;
  logic [AW-1:0]       pmem_address;
  logic                pmem_read;
  logic                pmem_write;
  logic [LW-1:0]       pmem_wdata;
  logic [LW-1:0]       pmem_rdata;
  logic                pmem_resp;
  arb_state_t          dbg_state;

  rr_mem_arbiter #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_address  (req_address),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .req_resp     (req_resp),
    .req_rdata    (req_rdata),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issued = 0;
  int n_done   = 0;

  logic [TW-1:0] exp_q[$];

  // Driver-side port state
  bit port_busy [NP];
  int port_left [NP];
  int port_gap  [NP];
  bit rand_wr_en = 1'b0;
  int max_gap    = 0;
  int fixed_lat  = 0;

  // Monitor-side observations used by directed checks
  int first_grant     = -1;
  int last_cmd_cycles = 0;

  function automatic logic [LW-1:0] mem_fn(input rv32i_word a);
    return {a ^ 32'h5A5A_C3C3, ~a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int mem_cnt = 0;
  int cur_lat = 1;
  always begin
    @(posedge clk); #1;
    if (rst) begin
      pmem_resp = 1'b0;
      mem_cnt   = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
    end else if (pmem_read || pmem_write) begin
      mem_cnt++;
      if (mem_cnt == 1) cur_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
      if (mem_cnt >= cur_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_fn(pmem_address);
        mem_cnt    = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int p, input bit wr, input rv32i_word a, input logic [LW-1:0] d);
    req_address[p*AW +: AW] = a;
    req_wdata[p*LW +: LW]   = d;
    req_read[p]  = !wr;
    req_write[p] = wr;
    port_busy[p] = 1'b1;
    n_issued++;
    exp_q.push_back({2'(p), wr, a, d});
  endtask

  task automatic clear_ports();
    req_read  = '0;
    req_write = '0;
    for (int p = 0; p < NP; p++) begin
      port_busy[p] = 1'b0;
      port_left[p] = 0;
      port_gap[p]  = 0;
    end
  endtask

  // One clock of requester behaviour; returns at posedge+1.
  task automatic step();
    logic [NP-1:0] snap;
    @(negedge clk);
    snap = req_resp;
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) begin
      if (port_busy[p]) begin
        if (snap[p]) begin
          port_busy[p] = 1'b0;
          req_read[p]  = 1'b0;
          req_write[p] = 1'b0;
          port_gap[p]  = $urandom_range(0, max_gap);
        end
      end else if (port_gap[p] > 0) begin
        port_gap[p]--;
      end else if (port_left[p] > 0) begin
        port_left[p]--;
        issue(p, rand_wr_en ? bit'($urandom_range(0, 1)) : 1'b0,
              rv32i_word'($urandom) & 32'hFFFF_FFE0, {$urandom, $urandom});
      end
    end
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n;
    bit busy;
    n = 0;
    do begin
      step();
      n++;
      busy = 1'b0;
      for (int p = 0; p < NP; p++) if (port_busy[p] || port_left[p] > 0) busy = 1'b1;
    end while (busy && n < budget);
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: ports still busy after %0d cycles, required idle", tag, n);
      clear_ports();
    end
  endtask

  task automatic wait_cmd(input int budget, input string tag);
    int n;
    n = 0;
    while (!(pmem_read || pmem_write) && n < budget) begin
      step();
      n++;
    end
    if (!(pmem_read || pmem_write)) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_timeout_%s: no memory command after %0d cycles, required one", tag, n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_ports();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          prev_cmd  = 1'b0;
  logic          prev_presp = 1'b0;
  logic [NP-1:0] prev_rd   = '0;
  logic [NP-1:0] prev_wr   = '0;
  int            model_last = NP - 1;
  int            cur_win   = -1;
  logic [TW-1:0] cur_entry = '0;
  int            cmd_cycles = 0;
  int            waits [NP];

  always @(negedge clk) begin
    logic          cmd;
    logic [NP-1:0] cands;
    logic [NP-1:0] exp_resp;
    int            win;
    int            found;
    cmd = pmem_read | pmem_write;
    if (rst) begin
      model_last  = NP - 1;
      cur_win     = -1;
      first_grant = -1;
      exp_q.delete();
      prev_cmd    = 1'b0;
      prev_presp  = 1'b0;
      for (int p = 0; p < NP; p++) waits[p] = 0;
    end else begin
      if (cmd && !prev_cmd) begin
`ifdef RR_ARBITER_WRITE_FIRST_EN
        cands = (prev_wr != '0) ? prev_wr : (prev_rd | prev_wr);
`else
        cands = prev_rd | prev_wr;
`endif
        // Expected winner: first pending candidate after the last served port.
        win = -1;
        for (int i = 1; i <= NP; i++)
          if (win < 0 && cands[(model_last + i) % NP]) win = (model_last + i) % NP;
        found = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (found < 0 && win >= 0 && int'(exp_q[i][TW-1 -: 2]) == win) found = i;
        if (found < 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant: unexpected command addr %0h, required winner port %0d", pmem_address, win);
          cur_win = -1;
        end else begin
          cur_entry = exp_q[found];
          exp_q.delete(found);
          cur_win = win;
          if (first_grant < 0) first_grant = win;
          check("cmd_write", pmem_write, cur_entry[LW+AW]);
          check("cmd_read", pmem_read, !cur_entry[LW+AW]);
          check("cmd_addr", pmem_address, cur_entry[LW +: AW]);
          if (cur_entry[LW+AW]) check("cmd_wdata", pmem_wdata, cur_entry[LW-1:0]);
        end
        cmd_cycles = 1;
      end else if (cmd) begin
        cmd_cycles++;
        if (cur_win >= 0) begin
          check("cmd_hold_addr", pmem_address, cur_entry[LW +: AW]);
          check("cmd_hold_dir", pmem_write, cur_entry[LW+AW]);
        end
      end

      exp_resp = '0;
      if (prev_presp && cur_win >= 0) exp_resp[cur_win] = 1'b1;
      check("req_resp", req_resp, exp_resp);
      if (exp_resp != '0) begin
        if (!cur_entry[LW+AW]) check("req_rdata", req_rdata, mem_fn(cur_entry[LW +: AW]));
`ifndef RR_ARBITER_WRITE_FIRST_EN
        check("fair_wait_le_np_minus_1", 128'(waits[cur_win] <= NP - 1), 128'(1));
`endif
        for (int p = 0; p < NP; p++)
          if (p != cur_win && (req_read[p] || req_write[p])) waits[p]++;
        waits[cur_win]  = 0;
        model_last      = cur_win;
        last_cmd_cycles = cmd_cycles;
        cur_win         = -1;
        n_done++;
      end
      prev_cmd   = cmd;
      prev_presp = pmem_resp;
    end
    prev_rd = req_read;
    prev_wr = req_write;
  end

  // ---------------- main sequence ----------------
  initial begin
    rst         = 1'b1;
    req_address = '0;
    req_read    = '0;
    req_write   = '0;
    req_wdata   = '0;
    pmem_rdata  = '0;
    pmem_resp   = 1'b0;
    clear_ports();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_req_resp", req_resp, '0);
    check("rst_req_rdata", req_rdata, '0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read, memory answers in the second BUSY cycle.
    fixed_lat = 2;
    issue(0, 1'b0, 32'h0000_0100, '0);
    run_until_idle(50, "single_read");
    check("single_read_cmd_cycles", last_cmd_cycles, 2);
    check("single_read_done", n_done, 1);

    // Port 1 write arrives while port 0 read is in flight.
    fixed_lat = 3;
    issue(0, 1'b0, 32'h0000_0140, '0);
    wait_cmd(20, "wr_behind_rd");
    issue(1, 1'b1, 32'h0000_0200, 64'hDEAD_C0DE_CAFE_BEEF);
    run_until_idle(50, "wr_behind_rd");
    check("wr_behind_rd_done", n_done, 3);

    // Reset during BUSY abandons the transaction and restores port-0 priority.
    fixed_lat = 10;
    issue(2, 1'b0, 32'h0000_0300, '0);
    wait_cmd(20, "rst_busy");
    step();
    rst = 1'b1;
    clear_ports();
    @(posedge clk);
    @(negedge clk);
    check("rst_busy_pmem_read", pmem_read, 1'b0);
    check("rst_busy_pmem_write", pmem_write, 1'b0);
    check("rst_busy_pmem_address", pmem_address, '0);
    check("rst_busy_req_resp", req_resp, '0);
    check("rst_busy_state", dbg_state, IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    fixed_lat = 1;
    issue(3, 1'b0, 32'h0000_0380, '0);
    issue(0, 1'b0, 32'h0000_0020, '0);
    run_until_idle(50, "after_rst");
    check("after_rst_first_grant", first_grant, 0);
    check("after_rst_done", n_done, 5);

    // Read on port 0 and write on port 1 in the same IDLE cycle after reset.
    do_reset();
    issue(0, 1'b0, 32'h0000_0400, '0);
    issue(1, 1'b1, 32'h0000_0420, 64'h0123_4567_89AB_CDEF);
    run_until_idle(50, "wr_first");
`ifdef RR_ARBITER_WRITE_FIRST_EN
    check("wr_first_grant", first_grant, 1);
`else
    check("wr_first_grant", first_grant, 0);
`endif

    // Slow memory: command held steady for ten cycles.
    fixed_lat = 10;
    issue(0, 1'b0, 32'h0000_0500, '0);
    run_until_idle(60, "slow_mem");
    check("slow_mem_cmd_cycles", last_cmd_cycles, 10);

    // All four ports reading continuously.
    fixed_lat  = 0;
    rand_wr_en = 1'b0;
    max_gap    = 0;
    for (int p = 0; p < NP; p++) port_left[p] = 8;
    run_until_idle(2000, "continuous");

    // Mixed random traffic.
    rand_wr_en = 1'b1;
    max_gap    = 3;
    for (int p = 0; p < NP; p++) port_left[p] = 40;
    run_until_idle(20000, "random");

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("all_completed", n_done, n_issued - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mem_arbiter.md
# rr_mem_arbiter

N-port round-robin arbiter that multiplexes cache-line read/write requests from `NUM_PORTS` caches onto a single physical-memory port. It sits between the L1 caches (I-cache, D-cache, and any later prefetch or victim buffer) and main memory. It generalises the two-port fixed arbiter with parametric port count, line width and address width, fair rotating priority, and registered memory-side outputs.

## Interface
Parameters:
- `NUM_PORTS`, 2, number of requesting caches (≥2)
- `LINE_WIDTH`, 256, cache-line width in bits
- `ADDR_WIDTH`, 32, address width

Ports:
- `clk`  in  1  the single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_address`  in  NUM_PORTS*ADDR_WIDTH  per-port line address; port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `req_read`  in  NUM_PORTS  per-port read request
- `req_write`  in  NUM_PORTS  per-port write request
- `req_wdata`  in  NUM_PORTS*LINE_WIDTH  per-port write line
- `req_resp`  out  NUM_PORTS  one-cycle completion pulse, one-hot
- `req_rdata`  out  LINE_WIDTH  read line, shared by all ports, valid while `req_resp` is high
- `pmem_address`  out  ADDR_WIDTH  memory address, registered
- `pmem_read` / `pmem_write`  out  1  memory commands, registered
- `pmem_wdata`  out  LINE_WIDTH  memory write line, registered
- `pmem_rdata`  in  LINE_WIDTH  memory read line
- `pmem_resp`  in  1  memory completion

## Operation
- Port i is "pending" when `req_read[i] | req_write[i]`. A port must hold its request and its data stable until it sees `req_resp[i]`, and must deassert the request in the cycle after `req_resp[i]`.
- Asserting both read and write on one port is a protocol error. The arbiter treats it as a write and raises a simulation-only assertion.
- FSM states:
  - IDLE → BUSY: when any port is pending. The arbiter picks the winner, latches the winner's index, address, wdata and direction into the `pmem_*` registers, and drives `pmem_read` or `pmem_write` high from the next cycle.
  - BUSY → DONE: when `pmem_resp` is high. On the same edge the arbiter captures `pmem_rdata` into the rdata register and clears `pmem_read` and `pmem_write`.
  - DONE → IDLE: unconditional. The arbiter asserts `req_resp[grant]` for exactly this one cycle and updates the priority pointer to `grant`.
  - BUSY with no `pmem_resp`: remain in BUSY and hold all `pmem_*` outputs.
- Round-robin: the search starts at `(last_grant+1) mod NUM_PORTS` and takes the first pending port. At reset `last_grant = NUM_PORTS-1`, so port 0 has the highest priority first. A port that was just served has the lowest priority in the next arbitration.
- Requests that arrive during BUSY or DONE wait. No request is dropped and none is reordered within a port.
- `req_rdata` holds its last captured value outside DONE. For write transactions it also carries the last captured value; it is not meaningful.

## Timing
- Reset values:
  - state = IDLE, `last_grant = NUM_PORTS-1`
  - `pmem_read` = 0, `pmem_write` = 0, `pmem_address` = 0, `pmem_wdata` = 0
  - `req_resp` = 0, `req_rdata` = 0
- Reset mid-transaction: the arbiter returns to IDLE on the reset edge, deasserts `pmem_*` commands in the following cycle, and abandons the transaction with no `req_resp`.
- Latency:
  - A request is sampled in IDLE at cycle t.
  - `pmem_read` or `pmem_write` is high at t+1.
  - If `pmem_resp` arrives at cycle t+k (k≥1), `req_resp` is high at t+k+1.
  - Minimum request-to-resp latency is 2 cycles after the sampling cycle.
- Back-to-back: after DONE the arbiter spends one IDLE cycle before the next grant, so a new memory command is issued no earlier than 2 cycles after the previous `pmem_resp`.
- `pmem_*` outputs are driven only from flops, with no combinational path from `req_*` to memory.
- `req_resp` is a flop output.

## Configuration
- `RR_ARBITER_WRITE_FIRST_EN`
  - Defined: in IDLE, if any port has `req_write` set, the round-robin search considers only write-pending ports. This drains dirty-line write-backs ahead of fills. The pointer still updates to the actual grant.
  - Undefined: reads and writes compete equally under pure round-robin.

## Structure
- A shared package `arbiter_types` holds:
  - `arb_state_t` enum {IDLE, BUSY, DONE}
  - a `clog2`-based index width constant helper
- Addresses narrower or equal to 32 bits reuse `rv32i_word` from `rv32i_types`.
- One sub-module, `rr_priority_picker`: combinational. Inputs are the pending vector and `last_grant`. Outputs are a one-hot grant and its index. It is parametrised on `NUM_PORTS`.
- The FSM, latches and registers live in `rr_mem_arbiter`. Expected size is about 200 lines.

## Test plan
- Single read, port 0, address 0x0000_0100, `pmem_resp` at the second BUSY cycle: `pmem_read` is high for 2 cycles; `req_resp[0]` pulses once with `req_rdata` = the driven `pmem_rdata`.
- `NUM_PORTS`=4, all ports reading continuously: grant order is 0,1,2,3,0…; no port waits more than 3 transactions.
- Port 1 writes 0xDEAD…BEEF to 0x0000_0200 while port 0 read is BUSY: the write is issued only after port 0's DONE, with `pmem_wdata` and `pmem_address` exact.
- With `RR_ARBITER_WRITE_FIRST_EN`, port 0 read and port 1 write pending in the same IDLE cycle at reset: port 1 is granted first. Without the macro, port 0 is granted first.
- `rst` asserted in BUSY: the next cycle is IDLE with all outputs 0, there is no `req_resp`, and the next request starts with port 0 priority.
- Port 0 read with 10-cycle memory latency: `pmem_address` and `pmem_read` are stable for all 10 cycles, and `req_resp` stays low until the cycle after `pmem_resp`.
